// File: rtl/fpu_dispatch_pkg.sv
// Shared types and constants for the FPU op dispatcher.
// FSM encoding, command bundle, control-word reset value, ESC opcodes.
package fpu_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int CMD_W = 96;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  sel;
        logic [79:0] data;
    } cmd_t;

    localparam logic [15:0] CTRL_RST = 16'h037F;

    localparam logic [7:0] ESC_D8 = 8'hD8;
    localparam logic [7:0] ESC_D9 = 8'hD9;
    localparam logic [7:0] ESC_DB = 8'hDB;
    localparam logic [7:0] ESC_DD = 8'hDD;
    localparam logic [7:0] ESC_DF = 8'hDF;

endpackage

// File: rtl/fpu_op_dispatcher_if.sv
// CPU-side command/control/response bundle of the FPU op dispatcher.
// master = CPU side, slave = dispatcher.
interface fpu_op_dispatcher_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [7:0]  cmd_sel;
    logic [79:0] cmd_data;
    logic        ctrl_wr;
    logic [15:0] ctrl_data;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [79:0] res_data;
    logic [15:0] res_status;
    logic        res_error;
    logic        res_timeout;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_data,
        output ctrl_wr, ctrl_data, flush, res_ready,
        input  cmd_ready, res_valid, res_data,
        input  res_status, res_error, res_timeout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_data,
        input  ctrl_wr, ctrl_data, flush, res_ready,
        output cmd_ready, res_valid, res_data,
        output res_status, res_error, res_timeout
    );

endinterface

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO with flush and a registered not-full flag.
// Pointers carry one extra wrap bit to tell full from empty.
module fpu_cmd_fifo
    import fpu_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         ready_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         ready_q, ready_d;
    logic         full, do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i && !full && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign data_o  = mem_q[rd_q[AW-1:0]];
    assign ready_o = ready_q;

    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, do_push};
        rd_d = rd_q + {{AW{1'b0}}, do_pop};
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end
        ready_d = !((wr_d[AW] != rd_d[AW]) &&
                    (wr_d[AW-1:0] == rd_d[AW-1:0]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/fpu_op_dispatcher.sv
// FPU command sequencer: queues ESC ops, issues one at a time, returns results.
// Define FPU_TIMEOUT_EN to add the WAIT watchdog and stale-completion guard.
module fpu_op_dispatcher
    import fpu_dispatch_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk,
    input  logic                reset,
    fpu_op_dispatcher_if.slave  host,
    output logic                core_start,
    output logic [7:0]          core_op,
    output logic [7:0]          core_sel,
    output logic [79:0]         core_data,
    input  logic                core_complete,
    input  logic [79:0]         core_result,
    input  logic [15:0]         core_status,
    input  logic                core_error,
    output logic [15:0]         core_ctrl,
    output logic                core_ctrl_update,
    output logic                busy,
    output logic [15:0]         issued_count
);

    state_e      state_q, state_d;
    cmd_t        cmd_in, head, op_q, op_d;
    logic [79:0] rdata_q, rdata_d;
    logic [15:0] rstat_q, rstat_d;
    logic        rerr_q, rerr_d, rtmo_q, rtmo_d;
    logic [15:0] ctrl_q, ctrl_d, cbuf_q, cbuf_d;
    logic        upd_q, upd_d, pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fifo_empty, fifo_ready, apply;
    logic        stale, tmo_hit;

    assign cmd_in = '{op: host.cmd_op, sel: host.cmd_sel, data: host.cmd_data};

    fpu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (host.cmd_valid && fifo_ready),
        .data_i  (cmd_in),
        .pop_i   (state_q == ST_ISSUE),
        .flush_i (host.flush),
        .data_o  (head),
        .empty_o (fifo_empty),
        .ready_o (fifo_ready)
    );

`ifdef FPU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          stale_q, stale_d;

    assign stale   = stale_q;
    assign tmo_hit = (state_q == ST_WAIT) && !core_complete &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d   = (state_q == ST_WAIT) ? tmo_q + TW'(1) : '0;
        stale_d = stale_q;
        if (tmo_hit) stale_d = 1'b1;
        else if (core_complete || host.flush) stale_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            stale_q <= stale_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
    assign stale      = 1'b0;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rdata_q <= '0;
            rstat_q <= '0;
            rerr_q  <= 1'b0;
            rtmo_q  <= 1'b0;
            ctrl_q  <= CTRL_RST;
            cbuf_q  <= '0;
            upd_q   <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            rstat_q <= rstat_d;
            rerr_q  <= rerr_d;
            rtmo_q  <= rtmo_d;
            ctrl_q  <= ctrl_d;
            cbuf_q  <= cbuf_d;
            upd_q   <= upd_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        rstat_d = rstat_q;
        rerr_d  = rerr_q;
        rtmo_d  = rtmo_q;
        unique case (state_q)
            ST_IDLE: begin
                // a pending control write or a flush holds off issue
                if (!pend_q && !fifo_empty && !stale && !host.flush) begin
                    state_d = ST_ISSUE;
                    op_d    = head;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_complete) begin
                    state_d = ST_RESP;
                    rdata_d = core_result;
                    rstat_d = core_status;
                    rerr_d  = core_error;
                    rtmo_d  = 1'b0;
                end else if (tmo_hit) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    rstat_d = core_status;
                    rerr_d  = 1'b1;
                    rtmo_d  = 1'b1;
                end
            end
            ST_RESP: if (host.res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        apply  = (state_q == ST_IDLE) && pend_q;
        ctrl_d = apply ? cbuf_q : ctrl_q;
        upd_d  = apply;
        cbuf_d = host.ctrl_wr ? host.ctrl_data : cbuf_q;
        pend_d = host.ctrl_wr ? 1'b1 : (apply ? 1'b0 : pend_q);
        cnt_d  = cnt_q + {15'd0, state_q == ST_ISSUE};
    end

    always_comb begin
        core_start       = (state_q == ST_ISSUE);
        core_op          = op_q.op;
        core_sel         = op_q.sel;
        core_data        = op_q.data;
        core_ctrl        = ctrl_q;
        core_ctrl_update = upd_q;
        busy             = (state_q != ST_IDLE) || !fifo_empty;
        issued_count     = cnt_q;
        host.cmd_ready   = fifo_ready;
        host.res_valid   = (state_q == ST_RESP);
        host.res_data    = rdata_q;
        host.res_status  = rstat_q;
        host.res_error   = rerr_q;
        host.res_timeout = rtmo_q;
    end

endmodule

// File: doc/fpu_op_dispatcher.md
Name: fpu_op_dispatcher

Overview:
Command sequencer in front of the FPU core wrapper.
- Buffers CPU-side FPU commands (opcode, ModRM select, 80-bit operand) in a FIFO.
- Issues them to the core one at a time with a single-cycle start pulse, waits for completion, and returns the result/status/error through a valid/ready response port.
- Also serialises control-word writes so they reach the core only between operations.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2.
TIMEOUT_CYCLES, 1023, WAIT-state watchdog limit (used only with FPU_TIMEOUT_EN).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_op  in  8  ESC opcode (D8..DF)
cmd_sel  in  8  ModRM/operand select
cmd_data  in  80  operand
ctrl_wr  in  1  control-word write strobe
ctrl_data  in  16  control word
flush  in  1  discard queued commands
res_valid  out  1  response available
res_ready  in  1  response accepted
res_data  out  80  result
res_status  out  16  core status at completion
res_error  out  1  core error or timeout
res_timeout  out  1  watchdog fired (0 when feature absent)
core_start  out  1  one-cycle start pulse
core_op  out  8  opcode to core
core_sel  out  8  select to core
core_data  out  80  operand to core
core_complete  in  1  completion pulse
core_result  in  80  core result
core_status  in  16  core status
core_error  in  1  core error
core_ctrl  out  16  control word to core
core_ctrl_update  out  1  one-cycle control update pulse
busy  out  1  FSM not IDLE or FIFO not empty
issued_count  out  16  commands issued, wraps at 0xFFFF->0

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1 and core_ctrl=16'h037F. FIFO empty, FSM in IDLE, ctrl_pending=0. Reset mid-operation abandons everything immediately; no response is produced.
- FIFO:
  - Push when cmd_valid&&cmd_ready.
  - cmd_ready = !full, registered; no same-cycle bypass when full.
  - Pointers are log2(DEPTH)+1 bits, so full and empty are distinguished across wrap.
- Control writes:
  - ctrl_wr loads ctrl_pending/ctrl_buf; a later write before application overwrites ctrl_buf.
  - In IDLE, a pending control write has priority over issue: core_ctrl<=ctrl_buf, core_ctrl_update=1 for one cycle, pending cleared. IDLE is then held that cycle.
- FSM states and transitions:
  - IDLE: if !empty and !pending and !stale -> ISSUE.
  - ISSUE: core_start=1 for exactly this cycle; core_op/sel/data driven from the FIFO head and held stable through WAIT; pop FIFO; issued_count+1 -> WAIT.
  - WAIT: on core_complete, capture core_result/status/error into res_* -> RESP.
  - RESP: res_valid=1 and res_* held until res_ready; on handshake -> IDLE.
- Latency:
  - Minimum accept-to-core_start is 2 cycles.
  - Complete-to-res_valid is 1 cycle.
  - Back-to-back: after a res handshake at cycle N, the next core_start is at N+2.
- Outstanding operations: exactly one; core_start is never issued while a previous operation is outstanding.
- core_complete outside WAIT is ignored, apart from clearing stale (see Optional Feature).
- flush:
  - Empties the FIFO in the same cycle; a simultaneous push is dropped.
  - Does not abort WAIT/RESP: the in-flight operation completes and its response is delivered.
  - Clears stale.
- Simultaneous push and pop on a non-full FIFO: both take effect; occupancy is unchanged.

Optional Feature:
FPU_TIMEOUT_EN.
- With the macro: a cycle counter runs in WAIT. If it reaches TIMEOUT_CYCLES without core_complete, go to RESP with res_data=0, res_status=core_status, res_error=1, res_timeout=1, and set stale.
  - While stale, IDLE does not issue.
  - The next core_complete, or flush, clears stale.
- Without the macro: WAIT waits indefinitely, res_timeout ties to 0, and no counter or stale logic exists.

Decomposition:
- Shared package fpu_dispatch_pkg: FSM state encoding (IDLE, ISSUE, WAIT, RESP), command struct width (8+8+80=96), control reset constant 16'h037F, and ESC opcode constants D8/D9/DB/DD/DF.
- One natural sub-module, fpu_cmd_fifo: parameterised synchronous FIFO with flush.

Test Plan:
- Single op: push D9/E8 -> core_start at +2 cycles, operands held; core_complete with result 3FFF8000000000000000 -> res_valid next cycle with that data; issued_count=1.
- Fill and back-pressure: push 5 commands with DEPTH=4 and the core stalled -> cmd_ready=0 after 4 entries queued (head popped on issue). Drain -> responses in FIFO order, with no core_start while WAIT/RESP.
- Control priority: ctrl_wr 16'h027F and queued command both present in IDLE -> core_ctrl_update pulse with 027F first, core_start the cycle after.
- Response stall: hold res_ready=0 for 10 cycles -> res_* stable, no new core_start; release -> next core_start 2 cycles after the handshake.
- Flush during WAIT with 3 queued -> FIFO empties, in-flight response still delivered, then busy=0.
- FPU_TIMEOUT_EN, TIMEOUT_CYCLES=20, no completion -> res_error=1 and res_timeout=1. Queued command is not issued until a late core_complete arrives; it then issues.
